// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode field geometry, fetch FSM encoding and default widths.
package cpu_pkg;
  localparam int OPCODE_W    = 4;
  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_KILL = 2'd2
  } fetch_state_e;

  // The opcode occupies the top OPCODE_W bits of an instruction word.
  function automatic int opcode_lsb(input int instr_w);
    return instr_w - OPCODE_W;
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO of {pc, instr}; flush outranks push/pop.
module fetch_queue #(
  parameter int AW = 8,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_pc,
  input  logic [IW-1:0] push_instr,
  output logic [AW-1:0] head_pc,
  output logic [IW-1:0] head_instr,
  output logic          full,
  output logic          empty,
  output logic [1:0]    count
);
  logic [AW-1:0] pc_r    [2];
  logic [IW-1:0] instr_r [2];
  logic          rd_ptr_r;
  logic          wr_ptr_r;
  logic [1:0]    count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign do_pop_s  = pop && (count_r != 2'd0);
  assign do_push_s = push && ((count_r != 2'd2) || do_pop_s);

  // Entry storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        pc_r[i]    <= {AW{1'b0}};
        instr_r[i] <= {IW{1'b0}};
      end
    end else if (flush) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) begin
        pc_r[wr_ptr_r]    <= push_pc;
        instr_r[wr_ptr_r] <= push_instr;
        wr_ptr_r          <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_pc    = pc_r[rd_ptr_r];
  assign head_instr = instr_r[rd_ptr_r];
  assign full       = (count_r == 2'd2);
  assign empty      = (count_r == 2'd0);
  assign count      = count_r;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem requests, 2-entry instruction queue
// and branch-redirect handling (stale responses are swallowed in KILL).
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [INSTR_W-1:0]  instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic [ADDR_W-1:0]   instr_pc
);
  localparam int OP_LSB = opcode_lsb(INSTR_W);

  fetch_state_e        state_r;
  fetch_state_e        state_s;
  logic [ADDR_W-1:0]   pc_r;
  logic [ADDR_W-1:0]   pc_s;
  logic [ADDR_W-1:0]   req_pc_r;
  logic                req_s;
  logic                fire_s;
  logic                push_s;
  logic                pop_s;
  logic                flush_s;
  logic [1:0]          q_count_s;
  logic                q_full_s;
  logic                q_empty_s;
  logic [ADDR_W-1:0]   head_pc_s;
  logic [INSTR_W-1:0]  head_instr_s;

  fetch_queue #(.AW(ADDR_W), .IW(INSTR_W)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush_s),
    .push       (push_s),
    .pop        (pop_s),
    .push_pc    (req_pc_r),
    .push_instr (imem_rdata),
    .head_pc    (head_pc_s),
    .head_instr (head_instr_s),
    .full       (q_full_s),
    .empty      (q_empty_s),
    .count      (q_count_s)
  );

  // Next-state, PC update and queue control; a redirect overrides everything else.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    push_s  = 1'b0;
    pop_s   = 1'b0;
    flush_s = 1'b0;
    req_s   = (state_r == ST_RUN) && (q_count_s < 2'd2) && !redirect_valid && !rst;
    fire_s  = req_s && imem_gnt;
    if (redirect_valid) begin
      flush_s = 1'b1;
      pc_s    = redirect_pc;
      case (state_r)
        ST_WAIT, ST_KILL: state_s = imem_rvalid ? ST_RUN : ST_KILL;
        ST_RUN:           state_s = ST_RUN;
        default:          state_s = ST_RUN;
      endcase
    end else begin
      pop_s = !q_empty_s && instr_ready;
      case (state_r)
        ST_RUN: begin
          if (fire_s) begin
            state_s = ST_WAIT;
            pc_s    = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            push_s  = 1'b1;
            state_s = ST_RUN;
          end else begin
            state_s = ST_WAIT;
          end
        end
        ST_KILL: begin
          if (imem_rvalid) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_KILL;
          end
        end
        default: state_s = ST_RUN;
      endcase
    end
  end

  // FSM state, PC and the address of the in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_RUN;
      pc_r     <= RESET_PC;
      req_pc_r <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      if (fire_s) begin
        req_pc_r <= pc_r;
      end
    end
  end

  assign imem_req    = req_s;
  assign imem_addr   = pc_r;
  assign instr_valid = !q_empty_s;
  assign instr       = q_empty_s ? {INSTR_W{1'b0}} : head_instr_s;
  assign instr_pc    = q_empty_s ? {ADDR_W{1'b0}} : head_pc_s;
  assign opcode      = instr[OP_LSB +: OPCODE_W];
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [7:0]  instr_pc;

  int vectors     = 0;
  int miscompares = 0;
  bit cmp_en      = 1'b0;

  // Model: next fetch address, buffered {pc,instr} entries, and the outstanding request
  // (0 = none, 1 = live and will be buffered, 2 = stale and will be dropped).
  logic [7:0]  pc_m     = 8'h00;
  logic [7:0]  req_pc_m = 8'h00;
  int          out_m    = 0;
  logic [23:0] q_m[$];

  fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .opcode         (opcode),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs applied during that cycle.
  task automatic model_update();
    bit req;
    if (rst) begin
      pc_m  = 8'h00;
      out_m = 0;
      q_m.delete();
      return;
    end
    req = (out_m == 0) && (q_m.size() < 2) && !redirect_valid;
    if (redirect_valid) begin
      q_m.delete();
      pc_m = redirect_pc;
      if (out_m != 0) out_m = imem_rvalid ? 0 : 2;
    end else begin
      if (q_m.size() > 0 && instr_ready) void'(q_m.pop_front());
      if (imem_rvalid && out_m == 1) q_m.push_back({req_pc_m, imem_rdata});
      if (imem_rvalid) out_m = 0;
      if (req && imem_gnt) begin
        req_pc_m = pc_m;
        pc_m     = pc_m + 8'd1;
        out_m    = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic        req_e;
      logic [15:0] ins_e;
      logic [7:0]  ipc_e;
      req_e = !rst && (out_m == 0) && (q_m.size() < 2) && !redirect_valid;
      ins_e = (q_m.size() > 0) ? q_m[0][15:0] : 16'h0000;
      ipc_e = (q_m.size() > 0) ? q_m[0][23:16] : 8'h00;
      chk("imem_req", {31'd0, imem_req}, {31'd0, req_e});
      chk("imem_addr", {24'd0, imem_addr}, {24'd0, pc_m});
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, q_m.size() > 0});
      chk("instr", {16'd0, instr}, {16'd0, ins_e});
      chk("instr_pc", {24'd0, instr_pc}, {24'd0, ipc_e});
      chk("opcode", {28'd0, opcode}, {16'd0, ins_e >> 12});
    end
  end

  initial begin
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 16'h0000;
    redirect_valid = 1'b0; redirect_pc = 8'h00; instr_ready = 1'b0;

    // Reset for two cycles: everything quiet
    tick(); cmp_en = 1'b1;
    settle();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", {16'd0, instr}, 32'd0);
    tick();
    rst = 1'b0; settle();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", {24'd0, imem_addr}, 32'h00);

    // In-order delivery of two instructions
    imem_gnt = 1'b1; instr_ready = 1'b1; tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 16'h1234; tick();
    imem_rvalid = 1'b0; settle();
    chk("d1_instr", {16'd0, instr}, 32'h1234);
    chk("d1_op", {28'd0, opcode}, 32'h1);
    chk("d1_pc", {24'd0, instr_pc}, 32'h00);
    chk("d1_addr", {24'd0, imem_addr}, 32'h01);
    imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 16'h5678; settle();
    chk("d2_empty", {31'd0, instr_valid}, 32'd0);
    tick();
    imem_rvalid = 1'b0; settle();
    chk("d2_instr", {16'd0, instr}, 32'h5678);
    chk("d2_op", {28'd0, opcode}, 32'h5);
    chk("d2_pc", {24'd0, instr_pc}, 32'h01);

    // Back-pressure: queue fills, request withheld, then drains in order
    instr_ready = 1'b0; imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 16'h9ABC; tick();
    imem_rvalid = 1'b0; imem_gnt = 1'b1; settle();
    chk("full_req", {31'd0, imem_req}, 32'd0);
    chk("full_addr", {24'd0, imem_addr}, 32'h03);
    tick(); settle();
    chk("full_hold", {24'd0, imem_addr}, 32'h03);
    chk("full_head", {16'd0, instr}, 32'h5678);
    imem_gnt = 1'b0; instr_ready = 1'b1; tick(); settle();
    chk("drain_head", {16'd0, instr}, 32'h9ABC);
    chk("drain_pc", {24'd0, instr_pc}, 32'h02);
    chk("reissue_req", {31'd0, imem_req}, 32'd1);
    tick(); settle();
    chk("drained", {31'd0, instr_valid}, 32'd0);

    // Redirect during WAIT; the stale response must vanish
    imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h40; tick();
    redirect_valid = 1'b0; settle();
    chk("kill_addr", {24'd0, imem_addr}, 32'h40);
    chk("kill_req", {31'd0, imem_req}, 32'd0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 16'hBEEF; tick();
    imem_rvalid = 1'b0; settle();
    chk("stale_gone", {31'd0, instr_valid}, 32'd0);
    chk("redir_req", {31'd0, imem_req}, 32'd1);
    imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 16'h3333; tick();
    imem_rvalid = 1'b0; settle();
    chk("redir_pc", {24'd0, instr_pc}, 32'h40);
    chk("redir_instr", {16'd0, instr}, 32'h3333);

    // rvalid, pop and redirect together with one entry queued
    instr_ready = 1'b0; imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 16'h7777; instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 8'h10; tick();
    imem_rvalid = 1'b0; redirect_valid = 1'b0; settle();
    chk("coll_valid", {31'd0, instr_valid}, 32'd0);
    chk("coll_req", {31'd0, imem_req}, 32'd1);
    chk("coll_addr", {24'd0, imem_addr}, 32'h10);

    // Address wrap 0xFF -> 0x00
    redirect_valid = 1'b1; redirect_pc = 8'hFF; tick();
    redirect_valid = 1'b0; settle();
    chk("wrap_addr0", {24'd0, imem_addr}, 32'hFF);
    imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0; settle();
    chk("wrap_addr1", {24'd0, imem_addr}, 32'h00);
    imem_rvalid = 1'b1; imem_rdata = 16'hA000; tick();
    imem_rvalid = 1'b0; settle();
    chk("wrap_pc0", {24'd0, instr_pc}, 32'hFF);
    chk("wrap_op0", {28'd0, opcode}, 32'hA);
    imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 16'hB001; tick();
    imem_rvalid = 1'b0; settle();
    chk("wrap_pc1", {24'd0, instr_pc}, 32'h00);
    chk("wrap_op1", {28'd0, opcode}, 32'hB);

    // Randomized traffic; memory only answers while a request is outstanding
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst            = ($urandom_range(0, 149) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = 8'($urandom);
      imem_gnt       = ($urandom_range(0, 3) != 0);
      imem_rvalid    = (out_m != 0) && ($urandom_range(0, 1) == 1);
      imem_rdata     = 16'($urandom);
      instr_ready    = ($urandom_range(0, 2) != 0);
    end
    tick();
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
